// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StRun,
        StErr
    } state_e;

    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned LenWidth     = 16;
    localparam logic [1:0]  LastByteIdx  = 2'(BytesPerWord - 1);

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid_o pulses one cycle
// after the fourth byte of each word.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        last_byte_o = byte_valid_i && (cnt_q == LastByteIdx);
        if (byte_valid_i) begin
            shift_d = {shift_q[23:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
            valid_d = last_byte_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= 32'h0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // The shift register holds the completed word throughout the pulse cycle.
    assign word_valid_o = valid_q;
    assign word_o       = shift_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: length header, big-endian words into instruction memory, then
// releases the core. Define PROG_LOADER_CHECKSUM_EN to add a trailing mod-256 checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e AfterLoad = StCsum;
`else
    localparam state_e AfterLoad = StRun;
`endif

    state_e                state_q, state_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [31:0]           addr_q, addr_d;
    logic                  accept;
    logic                  word_last;
    logic                  word_valid;
    logic [31:0]           word;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    assign rx_ready   = (state_q == StLenHi) || (state_q == StLenLo) ||
                        (state_q == StData)  || (state_q == StCsum);
    assign accept     = rx_valid && rx_ready;
    assign core_reset = (state_q != StRun);
    assign load_done  = (state_q == StRun);
    assign load_error = (state_q == StErr);
    assign imem_we    = word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = word;

    word_assembler u_word_assembler (
        .clk_i        (clk),
        .rst_i        (reset),
        .byte_valid_i (accept && (state_q == StData)),
        .byte_i       (rx_byte),
        .last_byte_o  (word_last),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        unique case (state_q)
            StLenHi: begin
                if (accept) begin
                    len_d   = {len_q[7:0], rx_byte};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = {len_q[7:0], rx_byte};
                    if (32'(len_d) > MAX_WORDS) begin
                        state_d = StErr;
                    end else if (len_d == '0) begin
                        state_d = AfterLoad;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                // Address is latched with the last byte so it is valid during the write pulse.
                if (word_last) begin
                    addr_d = BASE_ADDR + (32'(idx_q) << 2);
                    idx_d  = idx_q + IdxW'(1);
                    if (32'(idx_q) + 32'd1 == 32'(len_q)) begin
                        state_d = AfterLoad;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    state_d = (8'(sum_q + rx_byte) == 8'h00) ? StRun : StErr;
                end
            end
`endif
            StRun:   state_d = StRun;
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    assign sum_d = accept ? 8'(sum_q + rx_byte) : sum_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLenHi;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule
